// File: rtl/hash_op_ctrl.sv
// hash_op_ctrl: sequencing controller for a multi-way hash table held in URAM.
// It accepts one search/insert/delete request at a time, reads the addressed
// bucket, lets an external way arbiter pick a way, optionally writes one way
// back, and returns a response.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   op_valid/op_ready               request handshake
//   op_type/op_key/op_addr          00 search, 01 insert, 10 delete, 11 reserved
//   rd_en/rd_addr                   bucket read strobe and address
//   key_rd/opt_rd                   key and mode for the arbiter (opt_rd = 0: insert)
//   arbiter_result                  way-select vector, valid RD_LAT cycles after rd_en
//   wr_en/wr_addr/wr_way/wr_data    single-way write-back
//   rsp_valid/rsp_ready             response handshake
//   rsp_hit/rsp_full/rsp_way        key found / no free way / one-hot way used
//   op_cnt                          completed responses, wraps at 16 bits
module hash_op_ctrl #(
  parameter int NUM_MUL    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int KEY_WIDTH  = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [1:0]            op_type,
  input  logic [KEY_WIDTH-1:0]  op_key,
  input  logic [ADDR_WIDTH-1:0] op_addr,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [KEY_WIDTH-1:0]  key_rd,
  output logic [NUM_MUL-1:0]    opt_rd,
  input  logic [NUM_MUL-1:0]    arbiter_result,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [NUM_MUL-1:0]    wr_way,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_hit,
  output logic                  rsp_full,
  output logic [NUM_MUL-1:0]    rsp_way,
  output logic [15:0]           op_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_EVAL, S_WRITE, S_RESP
  } state_t;

  typedef enum logic [1:0] {
    OP_SEARCH = 2'b00,
    OP_INSERT = 2'b01,
    OP_DELETE = 2'b10,
    OP_RSVD   = 2'b11
  } op_t;

  state_t                state, state_nxt;
  op_t                   lat_type;
  logic [KEY_WIDTH-1:0]  lat_key;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [3:0]            lat_cnt;
  logic [NUM_MUL-1:0]    sel_way;
  logic [NUM_MUL-1:0]    way_reg;
  logic                  hit_reg;
  logic                  full_reg;
  logic [15:0]           cnt_reg;
  logic                  accept;
  logic                  eval_wr;
  logic [DATA_WIDTH-1:0] ins_data;

  // Lowest set bit of the arbiter vector (two's-complement isolate).
  assign sel_way = arbiter_result & (~arbiter_result + NUM_MUL'(1));

  assign accept  = (state == S_IDLE) && op_valid;
  assign eval_wr = (sel_way != '0) && ((lat_type == OP_INSERT) || (lat_type == OP_DELETE));

  always_comb begin
    ins_data                 = '0;
    ins_data[KEY_WIDTH-1:0]  = lat_key;
    ins_data[DATA_WIDTH-1]   = 1'b1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (op_valid) state_nxt = (op_t'(op_type) == OP_RSVD) ? S_RESP : S_READ;
      // EVAL must land exactly RD_LAT cycles after READ, so WAIT spans
      // RD_LAT-1 cycles and is skipped entirely for single-cycle reads.
      S_READ:  state_nxt = (RD_LAT == 1) ? S_EVAL : S_WAIT;
      S_WAIT:  if (lat_cnt <= 4'd1) state_nxt = S_EVAL;
      S_EVAL:  state_nxt = eval_wr ? S_WRITE : S_RESP;
      S_WRITE: state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request latch, latency counter, response fields, op counter
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_type <= OP_SEARCH;
      lat_key  <= '0;
      lat_addr <= '0;
      lat_cnt  <= '0;
      way_reg  <= '0;
      hit_reg  <= 1'b0;
      full_reg <= 1'b0;
      cnt_reg  <= '0;
    end else begin
      if (accept) begin
        lat_type <= op_t'(op_type);
        lat_key  <= op_key;
        lat_addr <= op_addr;
        way_reg  <= '0;
        hit_reg  <= 1'b0;
        full_reg <= 1'b0;
      end
      if (state == S_READ)      lat_cnt <= 4'(RD_LAT - 1);
      else if (state == S_WAIT) lat_cnt <= lat_cnt - 4'd1;
      if (state == S_EVAL) begin
        way_reg  <= sel_way;
        hit_reg  <= (sel_way != '0) && ((lat_type == OP_SEARCH) || (lat_type == OP_DELETE));
        full_reg <= (sel_way == '0) && (lat_type == OP_INSERT);
      end
      if ((state == S_RESP) && rsp_ready) cnt_reg <= cnt_reg + 16'd1;
    end
  end

  // Outputs
  always_comb begin
    op_ready  = (state == S_IDLE) && !rst;
    rd_en     = (state == S_READ);
    wr_en     = (state == S_WRITE);
    rsp_valid = (state == S_RESP);
    rd_addr   = lat_addr;
    wr_addr   = lat_addr;
    key_rd    = lat_key;
    opt_rd    = (lat_type == OP_INSERT) ? '0 : '1;
    wr_way    = way_reg;
    wr_data   = (lat_type == OP_INSERT) ? ins_data : '0;
    rsp_hit   = hit_reg;
    rsp_full  = full_reg;
    rsp_way   = way_reg;
    op_cnt    = cnt_reg;
  end

endmodule
